// File: rtl/uart_tx_arbiter_if.sv
// rtl/uart_tx_arbiter_if.sv - requester/UART-core bundle for the shared transmitter arbiter
interface uart_tx_arbiter_if #(
  parameter int NUM_REQ = 2
);
  logic [NUM_REQ-1:0]   req;
  logic [8*NUM_REQ-1:0] req_byte;
  logic [NUM_REQ-1:0]   ack;
  logic                 busy;
  logic                 tx_error;
  logic                 transmit;
  logic [7:0]           tx_byte;
  logic                 is_transmitting;

  modport master (
    output req, req_byte, is_transmitting,
    input  ack, busy, tx_error, transmit, tx_byte
  );

  modport slave (
    input  req, req_byte, is_transmitting,
    output ack, busy, tx_error, transmit, tx_byte
  );
endinterface

// File: rtl/uart_tx_arbiter.sv
// rtl/uart_tx_arbiter.sv - round-robin arbiter sharing one UART transmitter
module uart_tx_arbiter #(
  parameter int NUM_REQ       = 2,
  parameter int START_TIMEOUT = 1000
) (
  input  logic               clk,
  input  logic               rst,
  uart_tx_arbiter_if.slave   bus
);
  localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int TW = $clog2(START_TIMEOUT) + 1;

  typedef enum logic [2:0] {IDLE, START, WAIT, SEND, DONE} state_e;

  state_e        state_q, state_d;
  logic [PW-1:0] ptr_q, ptr_d;
  logic [PW-1:0] sel_q, sel_d;
  logic [7:0]    byte_q, byte_d;
  logic [TW-1:0] timer_q, timer_d;
  logic          tx_error_q, tx_error_d;

  logic          grant_found;
  logic [PW-1:0] grant_idx;
  logic [PW:0]   rr_sum;
  logic [PW-1:0] rr_idx;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      ptr_q      <= PW'(NUM_REQ - 1);
      sel_q      <= '0;
      byte_q     <= '0;
      timer_q    <= '0;
      tx_error_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      sel_q      <= sel_d;
      byte_q     <= byte_d;
      timer_q    <= timer_d;
      tx_error_q <= tx_error_d;
    end
  end

  // First requester after the last one served, wrapping modulo NUM_REQ.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = ptr_q;
    rr_sum      = '0;
    rr_idx      = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      rr_sum = {1'b0, ptr_q} + (PW+1)'(k);
      if (rr_sum >= (PW+1)'(NUM_REQ)) rr_sum = rr_sum - (PW+1)'(NUM_REQ);
      rr_idx = rr_sum[PW-1:0];
      if (!grant_found && bus.req[rr_idx]) begin
        grant_found = 1'b1;
        grant_idx   = rr_idx;
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    sel_d      = sel_q;
    byte_d     = byte_q;
    timer_d    = timer_q;
    tx_error_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (grant_found && !bus.is_transmitting) begin
          sel_d   = grant_idx;
          byte_d  = bus.req_byte[8*grant_idx +: 8];
          timer_d = '0;
          state_d = START;
        end
      end
      START: state_d = WAIT;
      WAIT: begin
        if (bus.is_transmitting) begin
          state_d = SEND;
        end else if (timer_q == TW'(START_TIMEOUT - 1)) begin
          // ptr is left alone so the same requester wins the retry.
          tx_error_d = 1'b1;
          state_d    = IDLE;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      SEND: begin
        if (!bus.is_transmitting) state_d = DONE;
      end
      DONE: begin
        ptr_d   = sel_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    bus.ack = '0;
    if (state_q == DONE) bus.ack[sel_q] = 1'b1;
    bus.busy     = (state_q != IDLE);
    bus.transmit = (state_q == START);
    bus.tx_byte  = byte_q;
    bus.tx_error = tx_error_q;
  end
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb/tb_uart_tx_arbiter.sv - directed self-checking bench for uart_tx_arbiter
module tb_uart_tx_arbiter;
  localparam int NUM_REQ = 2;
  localparam int ST      = 20;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  uart_tx_arbiter_if #(.NUM_REQ(NUM_REQ)) bus ();

  uart_tx_arbiter #(.NUM_REQ(NUM_REQ), .START_TIMEOUT(ST)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  logic model_en  = 1'b0;
  logic model_tx  = 1'b0;
  logic manual_tx = 1'b0;
  assign bus.is_transmitting = model_en ? model_tx : manual_tx;

  int checks = 0;
  int errors = 0;
  logic [7:0] sent_q[$];
  logic [1:0] ack_q[$];

  // UART core: line goes busy 2 cycles after transmit and stays busy 10 cycles.
  initial begin
    forever begin
      @(negedge clk);
      if (model_en && bus.transmit) begin
        repeat (2) @(negedge clk);
        model_tx = 1'b1;
        repeat (10) @(negedge clk);
        model_tx = 1'b0;
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (bus.transmit) sent_q.push_back(bus.tx_byte);
      if (bus.ack != '0) ack_q.push_back(bus.ack);
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_tx(output int n);
    n = -1;
    for (int i = 1; i <= 100; i++) begin
      @(negedge clk);
      if (bus.transmit) begin n = i; break; end
    end
  endtask

  task automatic wait_ack(output int n);
    n = -1;
    for (int i = 1; i <= 100; i++) begin
      @(negedge clk);
      if (bus.ack != '0) begin n = i; break; end
    end
  endtask

  task automatic wait_err(output int n);
    n = -1;
    for (int i = 1; i <= 100; i++) begin
      @(negedge clk);
      if (bus.tx_error) begin n = i; break; end
    end
  endtask

  initial begin
    int n;
    int tx_seen;
    bus.req      = '0;
    bus.req_byte = '0;

    rst = 1'b1;
    tick(3);
    check("rst_busy", 32'(bus.busy), 0);
    check("rst_ack", 32'(bus.ack), 0);
    check("rst_tx_error", 32'(bus.tx_error), 0);
    check("rst_transmit", 32'(bus.transmit), 0);
    check("rst_tx_byte", 32'(bus.tx_byte), 0);
    rst = 1'b0;

    // single byte from requester 0
    model_en     = 1'b1;
    bus.req_byte = {8'h00, 8'h41};
    bus.req      = 2'b01;
    tick(1);
    check("t1_transmit", 32'(bus.transmit), 1);
    check("t1_tx_byte", 32'(bus.tx_byte), 32'h41);
    check("t1_busy", 32'(bus.busy), 1);
    tick(1);
    check("t1_transmit_one_cycle", 32'(bus.transmit), 0);
    wait_ack(n);
    check("t1_ack_latency", 32'(n), 12);
    check("t1_ack", 32'(bus.ack), 32'b01);
    bus.req = '0;
    tick(1);
    check("t1_ack_pulse", 32'(bus.ack), 0);
    check("t1_busy_after", 32'(bus.busy), 0);
    check("t1_sent_count", 32'(sent_q.size()), 1);

    // both requesting: strict alternation from a fresh pointer
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    sent_q.delete();
    ack_q.delete();
    bus.req_byte = {8'h0D, 8'h30};
    bus.req      = 2'b11;
    for (int i = 0; i < 4; i++) begin
      wait_ack(n);
      check("t2_ack_seen", 32'(n > 0), 1);
    end
    bus.req = '0;
    tick(2);
    check("t2_sent_count", 32'(sent_q.size()), 4);
    check("t2_ack_count", 32'(ack_q.size()), 4);
    if (sent_q.size() == 4 && ack_q.size() == 4) begin
      check("t2_sent0", 32'(sent_q[0]), 32'h30);
      check("t2_sent1", 32'(sent_q[1]), 32'h0D);
      check("t2_sent2", 32'(sent_q[2]), 32'h30);
      check("t2_sent3", 32'(sent_q[3]), 32'h0D);
      check("t2_ack0", 32'(ack_q[0]), 32'b01);
      check("t2_ack1", 32'(ack_q[1]), 32'b10);
      check("t2_ack2", 32'(ack_q[2]), 32'b01);
      check("t2_ack3", 32'(ack_q[3]), 32'b10);
    end

    // start timeout, retry goes to the same requester
    model_en = 1'b0;
    manual_tx = 1'b0;
    sent_q.delete();
    ack_q.delete();
    bus.req_byte = {8'h66, 8'h55};
    bus.req      = 2'b11;
    wait_tx(n);
    check("t3_first_byte", 32'(bus.tx_byte), 32'h55);
    wait_err(n);
    check("t3_timeout_latency", 32'(n), ST + 1);
    check("t3_busy_on_error", 32'(bus.busy), 0);
    check("t3_ack_on_error", 32'(bus.ack), 0);
    tick(1);
    check("t3_error_pulse", 32'(bus.tx_error), 0);
    check("t3_retry_transmit", 32'(bus.transmit), 1);
    check("t3_retry_byte", 32'(bus.tx_byte), 32'h55);
    check("t3_no_ack", 32'(ack_q.size()), 0);
    bus.req = '0;
    rst = 1'b1;
    tick(1);
    rst = 1'b0;

    // reset during SEND, then pending request re-served
    model_en     = 1'b1;
    bus.req_byte = {8'h7E, 8'h00};
    bus.req      = 2'b10;
    wait_tx(n);
    check("t4_byte", 32'(bus.tx_byte), 32'h7E);
    tick(5);
    check("t4_busy_in_send", 32'(bus.busy), 1);
    rst = 1'b1;
    tick(1);
    check("t4_rst_busy", 32'(bus.busy), 0);
    check("t4_rst_ack", 32'(bus.ack), 0);
    check("t4_rst_transmit", 32'(bus.transmit), 0);
    check("t4_rst_tx_byte", 32'(bus.tx_byte), 0);
    rst = 1'b0;
    wait_tx(n);
    check("t4_retx_latency", 32'(n), 7);
    check("t4_retx_byte", 32'(bus.tx_byte), 32'h7E);
    wait_ack(n);
    check("t4_ack", 32'(bus.ack), 32'b10);
    bus.req = '0;
    tick(1);

    // line busy in IDLE holds off the grant
    model_en     = 1'b0;
    manual_tx    = 1'b1;
    bus.req_byte = {8'h00, 8'h5A};
    bus.req      = 2'b01;
    tx_seen = 0;
    repeat (6) begin
      tick(1);
      if (bus.transmit) tx_seen++;
    end
    check("t5_held_off", 32'(tx_seen), 0);
    check("t5_idle_busy", 32'(bus.busy), 0);
    manual_tx = 1'b0;
    tick(1);
    check("t5_transmit", 32'(bus.transmit), 1);
    check("t5_byte", 32'(bus.tx_byte), 32'h5A);
    tick(1);
    manual_tx = 1'b1;
    tick(2);
    check("t5_busy_send", 32'(bus.busy), 1);
    manual_tx = 1'b0;
    wait_ack(n);
    check("t5_ack_latency", 32'(n), 1);
    check("t5_ack", 32'(bus.ack), 32'b01);
    bus.req = '0;
    tick(1);

    // req dropped mid-transfer still completes with one ack
    model_en = 1'b1;
    sent_q.delete();
    ack_q.delete();
    bus.req_byte = {8'h00, 8'h99};
    bus.req      = 2'b01;
    wait_tx(n);
    check("t6_byte", 32'(bus.tx_byte), 32'h99);
    tick(5);
    bus.req = '0;
    wait_ack(n);
    check("t6_ack", 32'(bus.ack), 32'b01);
    tick(20);
    check("t6_sent_count", 32'(sent_q.size()), 1);
    check("t6_ack_count", 32'(ack_q.size()), 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
